// File: rtl/mem_port_mux_if.sv
// mem_port_mux_if
// Single-port memory bus between the port mux and the memory.
//   mem_en    : access strobe for this cycle
//   mem_we    : write strobe (valid with mem_en)
//   mem_addr  : word address
//   mem_wdata : write data
//   mem_rdata : read data, returned by the memory the cycle after a read
// Modports: master = the mux side, slave = the memory side.
interface mem_port_mux_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_mux.sv
// mem_port_mux
// Steers the master selected by the arbiter grant code onto the shared
// memory port and keeps a beat counter per master, so that a preempted
// multi-beat transfer picks up where it stopped.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   accmodule             : grant code (00 none, 01 M1, 10 M2, 11 M3)
//   m{1,2,3}_addr/wdata/we/len : per-master transfer request
//   done                  : one-hot, granted master issues its last beat now
//   rvalid, rdata         : read return, tagged to the master that issued it
//   nb_xfers              : completed transfers, saturating at 0xFFFF
//   mem                   : memory bus (master modport)
module mem_port_mux #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    accmodule,
  input  logic [AW-1:0] m1_addr,
  input  logic [AW-1:0] m2_addr,
  input  logic [AW-1:0] m3_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [DW-1:0] m2_wdata,
  input  logic [DW-1:0] m3_wdata,
  input  logic          m1_we,
  input  logic          m2_we,
  input  logic          m3_we,
  input  logic [LW-1:0] m1_len,
  input  logic [LW-1:0] m2_len,
  input  logic [LW-1:0] m3_len,
  output logic [2:0]    done,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [15:0]   nb_xfers,
  mem_port_mux_if.master mem
);

  logic [LW-1:0] cnt_q [3];
  logic [LW-1:0] cnt_d [3];
  logic [LW-1:0] len_q [3];
  logic [LW-1:0] len_d [3];
  logic [15:0]   nb_xfers_q, nb_xfers_d;
  logic [2:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          active;
  logic [1:0]    idx;
  logic [2:0]    grant_oh;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic [LW-1:0] sel_len;
  logic [LW-1:0] cur_cnt;
  logic [LW-1:0] eff_len;
  logic          last_beat;

  // Grant decode and request select. A beat only happens out of reset.
  always_comb begin
    idx       = 2'd0;
    grant_oh  = 3'b000;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_len   = '0;
    case (accmodule)
      2'b01: begin
        idx = 2'd0; grant_oh = 3'b001;
        sel_addr = m1_addr; sel_wdata = m1_wdata; sel_we = m1_we; sel_len = m1_len;
      end
      2'b10: begin
        idx = 2'd1; grant_oh = 3'b010;
        sel_addr = m2_addr; sel_wdata = m2_wdata; sel_we = m2_we; sel_len = m2_len;
      end
      2'b11: begin
        idx = 2'd2; grant_oh = 3'b100;
        sel_addr = m3_addr; sel_wdata = m3_wdata; sel_we = m3_we; sel_len = m3_len;
      end
      default: ;
    endcase
    active  = reset && (accmodule != 2'b00);
    cur_cnt = cnt_q[idx];
    // The live length only matters on beat 0; afterwards the latched length
    // rules, so a requester changing len mid-transfer has no effect.
    if (cur_cnt == '0) begin
      eff_len = (sel_len == '0) ? LW'(1) : sel_len;
    end else begin
      eff_len = len_q[idx];
    end
    last_beat = (cur_cnt == eff_len - LW'(1));
  end

  // Memory port and done are zero-latency so the arbiter can react to done
  // in the same cycle as the grant.
  always_comb begin
    mem.mem_en    = active;
    mem.mem_we    = active && sel_we;
    mem.mem_addr  = active ? (sel_addr + AW'(cur_cnt)) : '0;
    mem.mem_wdata = active ? sel_wdata : '0;
    done          = (active && last_beat) ? grant_oh : 3'b000;
  end

  // Next-state: only the granted master's counter moves; the others hold.
  // rdata_q follows mem_rdata while a return is in flight so the output
  // keeps the last returned word once rvalid drops.
  always_comb begin
    cnt_d      = cnt_q;
    len_d      = len_q;
    nb_xfers_d = nb_xfers_q;
    rvalid_d   = 3'b000;
    rdata_d    = rdata_q;
    if (rvalid_q != 3'b000) begin
      rdata_d = mem.mem_rdata;
    end
    if (active) begin
      if (cur_cnt == '0) begin
        len_d[idx] = eff_len;
      end
      if (last_beat) begin
        cnt_d[idx] = '0;
        if (nb_xfers_q != 16'hFFFF) begin
          nb_xfers_d = nb_xfers_q + 16'd1;
        end
      end else begin
        cnt_d[idx] = cur_cnt + LW'(1);
      end
      if (!sel_we) begin
        rvalid_d = grant_oh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
        len_q[i] <= '0;
      end
      nb_xfers_q <= '0;
      rvalid_q   <= 3'b000;
      rdata_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      nb_xfers_q <= nb_xfers_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // The memory returns read data during the cycle after the read beat, so
  // that word is passed straight through while rvalid is high.
  assign rvalid   = rvalid_q;
  assign rdata    = (rvalid_q != 3'b000) ? mem.mem_rdata : rdata_q;
  assign nb_xfers = nb_xfers_q;

endmodule
